frame_buffer_ctrl: RTL
======================

// Module: frame_buffer_ctrl
// PURPOSE
//  Double-buffered 320x180 RGB565 frame buffer between the transformation stage (ray pixel writes) and HDMI scan-out.
//  Transformation writes the back bank; scan-out reads the front bank, upscaled 4x to 1280x720.
//  Banks swap only at a frame boundary after the last ray pixel arrives, so no tearing.
//  frame_buff_ready_out is the back-pressure the transformation stage waits on after its last ray.
// PARAMETERS
//  PIXEL_WIDTH         16     bits per pixel (RGB565)
//  SCREEN_WIDTH        320    buffer columns
//  SCREEN_HEIGHT       180    buffer rows
//  SCALE_SHIFT         2      log2 upscale factor (1280x720 -> 320x180)
//  BRAM_LATENCY        2      read latency of fb_bram, cycles
// PORTS
//  pixel_clk_in        in   1   pixel clock; the only clock
//  rst_n_in            in   1   asynchronous, active-low reset
//  ray_valid_in        in   1   ray_address_in/ray_pixel_in valid this cycle
//  ray_address_in      in   16  back-bank write address, row*320+col
//  ray_pixel_in        in   16  pixel to write
//  ray_last_pixel_in   in   1   last pixel of frame; counted only with ray_valid_in
//  frame_buff_ready_out out 1   1 = back bank writable; 0 = swap pending
//  hcount_in           in   11  scan-out x, 0..1649
//  vcount_in           in   10  scan-out y, 0..749
//  active_draw_in      in   1   hcount/vcount inside 1280x720
//  new_frame_in        in   1   1-cycle pulse at scan-out frame start, in blanking
//  pixel_out           out  16  front-bank pixel for scan-out
//  pixel_valid_out     out  1   active_draw_in delayed to match pixel_out
//  front_bank_out      out  1   bank currently displayed
//  frame_count_out     out  8   completed swaps; wraps 255->0
// BEHAVIOUR
//  Reset: state=DRAW, front_bank=0, frame_buff_ready_out=1, pixel_out=0, pixel_valid_out=0, frame_count_out=0.
//   RAM contents are not cleared. Reset mid-frame drops any pending swap; pipelines are flushed.
//  State machine (fb_state_t):
//   DRAW: ready=1. If ray_valid_in, write ray_pixel_in to bank ~front at ray_address_in.
//    If ray_valid_in && ray_last_pixel_in, do that write, then next state is SWAP_PENDING and ready=0 next cycle.
//   SWAP_PENDING: ready=0. All ray writes are ignored.
//    On new_frame_in: front_bank toggles, frame_count++, next state is DRAW, ready=1 next cycle.
//  new_frame_in in DRAW: no swap; the same front bank is shown again.
//  new_frame_in in the same cycle as the last pixel: no swap that cycle; the swap waits for the next new_frame_in.
//  Write address >= SCREEN_WIDTH*SCREEN_HEIGHT (57600): write dropped, state unaffected.
//   A last pixel at an out-of-range address still triggers SWAP_PENDING.
//  Read path, 3-cycle latency from hcount/vcount to pixel_out:
//   c0: register raddr = (vcount_in>>2)*320 + (hcount_in>>2) (16 bits; shift-add, no multiplier) and front_bank.
//   c1-c2: fb_bram read.
//   pixel_out = 0 when the delayed active_draw_in is 0.
//  The bank used by the read pipeline is sampled at c0, so a swap never mixes banks within one pixel.
//  Read and write never target the same bank, so there is no RAM hazard.
// STRUCTURE
//  raycast_pkg: SCREEN_WIDTH/HEIGHT, FB_DEPTH=57600, fb_state_t {DRAW, SWAP_PENDING}, BACKGROUND_COLOR/WALL_COLOR.
//  Sub-module fb_bram: simple dual-port RAM, 2*FB_DEPTH x 16.
//   Address = {bank, addr}. Write port from rays, read port for scan-out, 2-cycle registered output.
//  Top-level holds the FSM, bank/frame counters, address scaling and the valid delay line.
// TESTING
//  1 Reset then idle: ready=1, front_bank=0, pixel_valid_out=0, pixel_out=0.
//  2 Write 0xF800 to addr 321, then last pixel at addr 57599.
//    -> ready=0 next cycle. On new_frame_in: front_bank=1, ready=1, frame_count=1.
//    -> At hcount=4..7, vcount=4..7: pixel_out=0xF800, 3 cycles after the inputs.
//  3 Writes while SWAP_PENDING (addr 0, 0x1234) -> bank 1 addr 0 unchanged on the next displayed frame.
//  4 new_frame_in with no last pixel -> no swap, frame_count unchanged.
//    Last pixel on the same cycle as new_frame_in -> swap only on the following pulse.
//  5 Write to addr 60000 -> no RAM change. Last pixel at addr 60000 -> still enters SWAP_PENDING.
//  6 Assert rst_n_in low mid-SWAP_PENDING -> immediate DRAW, ready=1, front_bank=0, pixel_valid_out=0.
//    Run 256 swaps -> frame_count_out wraps to 0.

Source files
------------

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared definitions for the double-buffered frame buffer controller.
// Holds the buffer geometry, the controller state type, two reference colours
// and the scan-out to buffer address scaling helper.
package frame_buffer_ctrl_pkg;

  localparam int PIXEL_WIDTH   = 16;
  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;
  localparam int SCALE_SHIFT   = 2;
  localparam int BRAM_LATENCY  = 2;
  localparam int FB_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;

  // 16-bit copy of the depth so address compares stay width-matched.
  localparam logic [15:0] FB_DEPTH_A = 16'(FB_DEPTH);

  localparam logic [PIXEL_WIDTH-1:0] BACKGROUND_COLOR = 16'h0000;
  localparam logic [PIXEL_WIDTH-1:0] WALL_COLOR       = 16'hF800;

  typedef enum logic {
    DRAW         = 1'b0,
    SWAP_PENDING = 1'b1
  } fb_state_t;

  // Maps a 1280x720 scan position onto the 320x180 buffer.
  // row*320 is built as row*256 + row*64 so no multiplier is inferred.
  function automatic logic [15:0] scale_addr(input logic [10:0] h, input logic [9:0] v);
    logic [15:0] row;
    logic [15:0] col;
    row = 16'(v >> SCALE_SHIFT);
    col = 16'(h >> SCALE_SHIFT);
    return (row << 8) + (row << 6) + col;
  endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Bus bundle between the frame buffer controller and its neighbours:
// the ray write port from the transformation stage, the scan-out timing
// inputs, and the displayed pixel / status outputs.
//   master : transformation stage + scan-out side (drives ray_* and timing)
//   slave  : frame_buffer_ctrl
interface frame_buffer_ctrl_if;
  import frame_buffer_ctrl_pkg::*;

  logic                   ray_valid_in;
  logic [15:0]            ray_address_in;
  logic [PIXEL_WIDTH-1:0] ray_pixel_in;
  logic                   ray_last_pixel_in;
  logic                   frame_buff_ready_out;
  logic [10:0]            hcount_in;
  logic [9:0]             vcount_in;
  logic                   active_draw_in;
  logic                   new_frame_in;
  logic [PIXEL_WIDTH-1:0] pixel_out;
  logic                   pixel_valid_out;
  logic                   front_bank_out;
  logic [7:0]             frame_count_out;

  modport master (
    output ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
    output hcount_in, vcount_in, active_draw_in, new_frame_in,
    input  frame_buff_ready_out, pixel_out, pixel_valid_out,
    input  front_bank_out, frame_count_out
  );

  modport slave (
    input  ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
    input  hcount_in, vcount_in, active_draw_in, new_frame_in,
    output frame_buff_ready_out, pixel_out, pixel_valid_out,
    output front_bank_out, frame_count_out
  );

endinterface

// File: rtl/frame_buffer_ctrl_fb_bram.sv
// Simple dual-port RAM holding both frame banks (2 x 57600 x 16).
// Ports:
//   clk            clock
//   we/wbank/waddr/wdata  write port (ray pixels, back bank)
//   rbank/raddr    read address (scan-out, front bank)
//   rdata          read data, two registered stages after rbank/raddr
module frame_buffer_ctrl_fb_bram
  import frame_buffer_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic                   wbank,
  input  logic [15:0]            waddr,
  input  logic [PIXEL_WIDTH-1:0] wdata,
  input  logic                   rbank,
  input  logic [15:0]            raddr,
  output logic [PIXEL_WIDTH-1:0] rdata
);

  logic [PIXEL_WIDTH-1:0] mem [2][FB_DEPTH];
  logic [PIXEL_WIDTH-1:0] rd_p1;
  logic [PIXEL_WIDTH-1:0] rd_p2;

  always_ff @(posedge clk) begin
    if (we && (waddr < FB_DEPTH_A)) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  // Stage p1: array read (out-of-buffer addresses only occur in blanking)
  always_ff @(posedge clk) begin
    if (raddr < FB_DEPTH_A) begin
      rd_p1 <= mem[rbank][raddr];
    end else begin
      rd_p1 <= '0;
    end
  end

  // Stage p2: output register
  always_ff @(posedge clk) begin
    rd_p2 <= rd_p1;
  end

  assign rdata = rd_p2;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered 320x180 RGB565 frame buffer controller.
// Rays write the back bank; scan-out reads the front bank upscaled 4x.
// Banks swap on the first new_frame_in after the last ray pixel, so a
// displayed frame is never torn.
// Ports:
//   pixel_clk_in   the only clock
//   rst_n_in       asynchronous active-low reset
//   bus            frame_buffer_ctrl_if.slave: ray writes, scan timing,
//                  pixel_out/pixel_valid_out, ready, front bank, frame count
module frame_buffer_ctrl
  import frame_buffer_ctrl_pkg::*;
(
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  frame_buffer_ctrl_if.slave  bus
);

  fb_state_t              state_q, state_d;
  logic                   front_bank_q, front_bank_d;
  logic [7:0]             frame_count_q, frame_count_d;
  logic                   wr_en;

  logic [15:0]            raddr_p0;
  logic                   bank_p0;
  logic                   vld_p0, vld_p1, vld_p2;
  logic [PIXEL_WIDTH-1:0] rdata_p2;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= DRAW;
      front_bank_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      front_bank_q  <= front_bank_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    front_bank_d  = front_bank_q;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    case (state_q)
      DRAW: begin
        // The last pixel is still written; range check happens in the RAM.
        wr_en = bus.ray_valid_in;
        if (bus.ray_valid_in && bus.ray_last_pixel_in) begin
          state_d = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (bus.new_frame_in) begin
          state_d       = DRAW;
          front_bank_d  = ~front_bank_q;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
    endcase
  end

  // Stage p0: scaled read address and bank captured together so a swap
  // cannot split one pixel across banks
  always_ff @(posedge pixel_clk_in) begin
    raddr_p0 <= scale_addr(bus.hcount_in, bus.vcount_in);
    bank_p0  <= front_bank_q;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= bus.active_draw_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stages p1-p2: RAM read inside fb_bram
  frame_buffer_ctrl_fb_bram u_fb_bram (
    .clk   (pixel_clk_in),
    .we    (wr_en),
    .wbank (~front_bank_q),
    .waddr (bus.ray_address_in),
    .wdata (bus.ray_pixel_in),
    .rbank (bank_p0),
    .raddr (raddr_p0),
    .rdata (rdata_p2)
  );

  assign bus.pixel_out            = vld_p2 ? rdata_p2 : '0;
  assign bus.pixel_valid_out      = vld_p2;
  assign bus.frame_buff_ready_out = (state_q == DRAW);
  assign bus.front_bank_out       = front_bank_q;
  assign bus.frame_count_out      = frame_count_q;

endmodule
